// File: rtl/ex_div_if.sv
// ex_div_if: handshake/data bundle between the EX stage and the divide
// sequencer.
//   start_i    - divide request, held high by EX for the whole operation
//   annul_i    - cancel an in-flight divide (flush/exception)
//   signed_i   - 1 = DIV (two's complement), 0 = DIVU
//   opdata1_i  - dividend, sampled only at acceptance
//   opdata2_i  - divisor, sampled only at acceptance
//   result_o   - {remainder, quotient}
//   ready_o    - result valid (registered)
//   stallreq_o - stall request to the pipeline controller (combinational)
// The master modport is the EX side; the slave modport is the divider.
interface ex_div_if #(
  parameter int WIDTH = 32
);
  logic               start_i;
  logic               annul_i;
  logic               signed_i;
  logic [WIDTH-1:0]   opdata1_i;
  logic [WIDTH-1:0]   opdata2_i;
  logic [2*WIDTH-1:0] result_o;
  logic               ready_o;
  logic               stallreq_o;

  modport master (
    output start_i, annul_i, signed_i, opdata1_i, opdata2_i,
    input  result_o, ready_o, stallreq_o
  );

  modport slave (
    input  start_i, annul_i, signed_i, opdata1_i, opdata2_i,
    output result_o, ready_o, stallreq_o
  );
endinterface

// File: rtl/ex_div_ctrl.sv
// ex_div_ctrl: multi-cycle restoring divide sequencer for the EX stage.
// Produces one quotient bit per cycle on operand magnitudes, then applies
// sign correction, and holds a stall request until the result is ready.
// Ports:
//   clk - clock, all state on the rising edge
//   rst - asynchronous active-high reset, clears all state and outputs
//   div - ex_div_if slave modport (request, operands, result, ready, stall)
module ex_div_ctrl #(
  parameter int WIDTH = 32
) (
  input logic     clk,
  input logic     rst,
  ex_div_if.slave div
);

  localparam int                CNT_W    = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0]  CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WIDTH);
  localparam logic [WIDTH-1:0]  ZERO_W   = {WIDTH{1'b0}};

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_DIVZERO = 2'd1,
    ST_ON      = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  // Two's-complement negation on WIDTH bits.
  function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] v);
    return ~v + {{(WIDTH-1){1'b0}}, 1'b1};
  endfunction

  state_t             state_r, state_nx_s;
  logic [WIDTH-1:0]   rem_r, rem_nx_s;     // partial remainder
  logic [WIDTH-1:0]   quo_r, quo_nx_s;     // dividend shifting out, quotient shifting in
  logic [WIDTH-1:0]   dsr_r, dsr_nx_s;     // divisor magnitude
  logic [CNT_W-1:0]   cnt_r, cnt_nx_s;
  logic               neg_q_r, neg_q_nx_s; // quotient needs negation
  logic               neg_r_r, neg_r_nx_s; // remainder needs negation
  logic [2*WIDTH-1:0] result_r, result_nx_s;
  logic               ready_r, ready_nx_s;
  logic [WIDTH:0]     trial_s;
  logic               go_s;

  // Shifted remainder (with next dividend bit) minus divisor; MSB set means the
  // subtraction would go negative, so the remainder is restored.
  assign trial_s = {rem_r, quo_r[WIDTH-1]} - {1'b0, dsr_r};
  assign go_s    = div.start_i & ~div.annul_i;

  assign div.result_o   = result_r;
  assign div.ready_o    = ready_r;
  assign div.stallreq_o = go_s & ~ready_r;

  // State register and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= ST_IDLE;
      rem_r    <= ZERO_W;
      quo_r    <= ZERO_W;
      dsr_r    <= ZERO_W;
      cnt_r    <= CNT_ZERO;
      neg_q_r  <= 1'b0;
      neg_r_r  <= 1'b0;
      result_r <= {2*WIDTH{1'b0}};
      ready_r  <= 1'b0;
    end else begin
      state_r  <= state_nx_s;
      rem_r    <= rem_nx_s;
      quo_r    <= quo_nx_s;
      dsr_r    <= dsr_nx_s;
      cnt_r    <= cnt_nx_s;
      neg_q_r  <= neg_q_nx_s;
      neg_r_r  <= neg_r_nx_s;
      result_r <= result_nx_s;
      ready_r  <= ready_nx_s;
    end
  end

  // Next-state and datapath update logic.
  always_comb begin
    state_nx_s  = state_r;
    rem_nx_s    = rem_r;
    quo_nx_s    = quo_r;
    dsr_nx_s    = dsr_r;
    cnt_nx_s    = cnt_r;
    neg_q_nx_s  = neg_q_r;
    neg_r_nx_s  = neg_r_r;
    result_nx_s = result_r;
    ready_nx_s  = ready_r;

    case (state_r)
      ST_IDLE: begin
        if (go_s) begin
          if (div.opdata2_i == ZERO_W) begin
            state_nx_s = ST_DIVZERO;
          end else begin
            if (div.signed_i && div.opdata1_i[WIDTH-1]) begin
              quo_nx_s = negate(div.opdata1_i);
            end else begin
              quo_nx_s = div.opdata1_i;
            end
            if (div.signed_i && div.opdata2_i[WIDTH-1]) begin
              dsr_nx_s = negate(div.opdata2_i);
            end else begin
              dsr_nx_s = div.opdata2_i;
            end
            neg_q_nx_s = div.signed_i & (div.opdata1_i[WIDTH-1] ^ div.opdata2_i[WIDTH-1]);
            neg_r_nx_s = div.signed_i & div.opdata1_i[WIDTH-1];
            rem_nx_s   = ZERO_W;
            cnt_nx_s   = CNT_ZERO;
            state_nx_s = ST_ON;
          end
        end else begin
          state_nx_s = ST_IDLE;
        end
      end

      ST_DIVZERO: begin
        rem_nx_s   = ZERO_W;
        quo_nx_s   = ZERO_W;
        state_nx_s = ST_DONE;
      end

      ST_ON: begin
        // Dropping start_i mid-divide counts as a cancel.
        if (!go_s) begin
          state_nx_s = ST_IDLE;
        end else if (cnt_r == CNT_LAST) begin
          // Corrected values go back into the working registers too, so DONE
          // can reload result from them without redoing the correction.
          if (neg_q_r) begin
            quo_nx_s = negate(quo_r);
          end else begin
            quo_nx_s = quo_r;
          end
          if (neg_r_r) begin
            rem_nx_s = negate(rem_r);
          end else begin
            rem_nx_s = rem_r;
          end
          result_nx_s = {rem_nx_s, quo_nx_s};
          ready_nx_s  = 1'b1;
          state_nx_s  = ST_DONE;
        end else begin
          if (trial_s[WIDTH]) begin
            rem_nx_s = {rem_r[WIDTH-2:0], quo_r[WIDTH-1]};
          end else begin
            rem_nx_s = trial_s[WIDTH-1:0];
          end
          quo_nx_s = {quo_r[WIDTH-2:0], ~trial_s[WIDTH]};
          cnt_nx_s = cnt_r + CNT_ONE;
        end
      end

      ST_DONE: begin
        // Entering from DIVZERO, ready is raised one edge after entry.
        if (!div.start_i) begin
          ready_nx_s  = 1'b0;
          result_nx_s = {2*WIDTH{1'b0}};
          state_nx_s  = ST_IDLE;
        end else begin
          ready_nx_s  = 1'b1;
          result_nx_s = {rem_r, quo_r};
          state_nx_s  = ST_DONE;
        end
      end

      default: begin
        state_nx_s = ST_IDLE;
      end
    endcase
  end

endmodule

// File: doc/ex_div_ctrl.md
Name: ex_div_ctrl

Overview:
- Multi-cycle divide sequencer for the EX stage.
- Accepts a DIV/DIVU request from the EX ALU decode (aluop) and runs a restoring shift-subtract divide, one quotient bit per cycle.
- Holds a stall request to the pipeline controller until the result is ready.
- Delivers {remainder, quotient} for the HI/LO write path.

Parameters:
- WIDTH, 32, operand width; result is 2*WIDTH.

Ports:
- clk  input  1  clock; all state on rising edge.
- rst  input  1  reset, asynchronous, active-high; clears all state and outputs.
- start_i  input  1  divide request; held high by EX for the whole operation.
- annul_i  input  1  cancel in-flight divide (flush/exception).
- signed_i  input  1  1 = DIV (two's complement), 0 = DIVU.
- opdata1_i  input  WIDTH  dividend; sampled only at acceptance.
- opdata2_i  input  WIDTH  divisor; sampled only at acceptance.
- result_o  output  2*WIDTH  {remainder[2W-1:W], quotient[W-1:0]}.
- ready_o  output  1  result valid (registered).
- stallreq_o  output  1  stall request to the pipeline controller (combinational).

Behaviour:
- Reset, and any rst assertion including mid-operation:
  - state = IDLE, result_o = 0, ready_o = 0, counter = 0, working registers = 0.
  - Takes effect immediately, without a clock edge.
- States: IDLE, DIVZERO, ON, DONE.
- IDLE:
  - Acceptance is start_i=1 and annul_i=0 at an edge.
  - On acceptance with opdata2_i==0: go to DIVZERO.
  - On acceptance with nonzero divisor:
    - Latch the operand magnitudes. If signed_i=1, take the two's-complement magnitude of each negative operand; otherwise use the operands as is.
    - Latch signed_i and both operand sign bits.
    - Clear the partial remainder and set counter = 0.
    - Go to ON.
  - Otherwise stay in IDLE.
- DIVZERO: next edge sets the working result to 0 and goes to DONE.
- ON:
  - If annul_i=1: go to IDLE at the next edge. ready_o stays 0 and result_o is unchanged (0).
  - Otherwise, each edge performs one iteration:
    - Shift the {partial remainder, dividend} pair left by 1.
    - Compute trial = partial remainder − |divisor| on WIDTH+1 bits.
    - If trial is non-negative, the remainder takes trial and the quotient LSB is 1; else the quotient LSB is 0.
    - counter increments.
  - After the WIDTH-th iteration, the next edge applies sign correction and goes to DONE.
    - Negate the quotient if signed and the operand signs differ.
    - Negate the remainder if signed and the dividend is negative.
- DONE:
  - ready_o = 1; result_o = corrected {remainder, quotient}, registered on entry.
  - Stays in DONE while start_i=1.
  - When start_i=0 at an edge: go to IDLE, ready_o = 0, result_o = 0.
- Latency, counting the acceptance edge as edge 0:
  - Nonzero divisor: ready_o is high after edge WIDTH+1 (33 for WIDTH=32).
  - Divide-by-zero: ready_o is high after edge 2.
- stallreq_o = start_i & ~annul_i & ~ready_o.
  - High in the acceptance cycle and throughout ON and DIVZERO.
  - Low once ready_o rises, so EX advances exactly one cycle later.
- Signed overflow, 0x8000_0000 / 0xFFFF_FFFF: quotient = 0x8000_0000 and remainder = 0, by natural wrap; no trap.
- Operand changes after acceptance are ignored.
- start_i dropping while in ON without annul_i is treated as an annul.
- annul_i in DONE: DONE → IDLE follows the start_i rule only; annul_i has no effect.
- annul_i and start_i both high in IDLE: no acceptance.

Test Plan:
- Unsigned: signed_i=0, 100 / 7 held with start_i → stallreq_o high for edges 0..32; ready_o rises after edge 33; result_o = {0x0000_0002, 0x0000_000E}.
- Signed mixed signs: −7 / 2 (0xFFFF_FFF9, 0x2) → quotient 0xFFFF_FFFD, remainder 0xFFFF_FFFF. Repeat with 7 / −2 → quotient 0xFFFF_FFFD, remainder 0x1.
- Divide-by-zero: 0x1234 / 0 → ready_o after edge 2, result_o = 0. Then drop start_i → ready_o = 0 and state IDLE the next edge.
- Annul: start 0xFFFF_FFFF / 3 unsigned, raise annul_i at edge 10 → ready_o never rises, stallreq_o low. A following 9 / 3 yields quotient 3, remainder 0 on schedule.
- Overflow/extremes: signed 0x8000_0000 / 0xFFFF_FFFF → {0, 0x8000_0000}. Unsigned 0xFFFF_FFFF / 1 → {0, 0xFFFF_FFFF}.
- Async reset mid-ON at edge 15 → outputs 0 immediately without a clock edge. After reset release, 50 / 8 → {0x2, 0x6} with full latency.
